// File: rtl/uart_tx_port_pkg.sv
// Shared definitions for the memory-mapped UART transmitter.
// Holds the register offsets within the 2-byte window, the STATUS bit
// indices, the transmitter FSM state encodings and the baud divider
// helper. Imported by uart_tx_port and available to a later receiver.
// Optional feature macro (used by the top level): UART_TX_PARITY_EN.
package uart_tx_port_pkg;

  // Register offsets relative to BASE_ADDR
  localparam logic [15:0] UART_DATA   = 16'd0;
  localparam logic [15:0] UART_STATUS = 16'd1;

  // STATUS register bit indices; bits [7:4] read as zero
  localparam int unsigned STAT_BUSY     = 0;
  localparam int unsigned STAT_FULL     = 1;
  localparam int unsigned STAT_EMPTY    = 2;
  localparam int unsigned STAT_OVERFLOW = 3;

  // Transmitter FSM states. ST_PARITY is only entered when parity is built in.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_t;

  // Clocks per bit, rounded to nearest: (CLK_HZ + BAUD/2) / BAUD
  function automatic int unsigned calc_div(input int unsigned clk_hz,
                                           input int unsigned baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_tx_port_fifo.sv
// sync_fifo: single-clock FIFO with synchronous active-high reset.
// Written generically so a future receiver port can reuse it.
// Ports:
//   clock, reset        clock and synchronous reset (flushes the FIFO)
//   push, push_data     write request and data
//   pop, pop_data       read request; pop_data shows the head entry
//                       (first-word fall-through)
//   full, empty         occupancy flags
//   dropped             a push was refused this cycle (full, no pop)
//   count               number of stored entries, 0..DEPTH
// DEPTH must be a power of two >= 2 so the pointers wrap naturally.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  output logic                   full,
  output logic                   empty,
  output logic                   dropped,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW + 1)'(DEPTH));
  // A pop only happens when there is something to pop. A push into a full
  // FIFO is still taken when a pop frees a slot in the same cycle.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dropped = push & ~do_push;

  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_port.sv
// uart_tx_port: memory-mapped UART transmitter on the CPU bus.
// Bytes written to BASE+0 are queued in a FIFO and sent LSB first on tx.
// BASE+1 reads STATUS: [0] busy, [1] full, [2] empty, [3] overflow (sticky,
// cleared by a STATUS read).
// Macro UART_TX_PARITY_EN: defined -> 8E1 frames (even parity bit),
//                          undefined -> 8N1 frames.
// Ports:
//   clock, reset    system clock, synchronous active-high reset
//   address         CPU address bus
//   write_en        CPU write strobe
//   data_in         CPU write data
//   data_out        registered read data, 8'h00 when not selected
//   tx              serial line, idle high
//   irq_empty       high while the FIFO is empty and the FSM is idle
//   state_dbg       current FSM state encoding (tx_state_t)
//   fifo_count_dbg  current FIFO occupancy
// Bus handshake: there is no stall. A write is taken on any rising clock
// edge where write_en is high and address decodes; a read is any edge where
// write_en is low and address decodes, with data_out valid after that edge.
module uart_tx_port
  import uart_tx_port_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR  = 16'hF200,
  parameter int unsigned CLK_HZ     = 5000000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [15:0]                 address,
  input  logic                        write_en,
  input  logic [7:0]                  data_in,
  output logic [7:0]                  data_out,
  output logic                        tx,
  output logic                        irq_empty,
  output logic [2:0]                  state_dbg,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count_dbg
);

  localparam int unsigned DIV = calc_div(CLK_HZ, BAUD);
  localparam int unsigned TW  = $clog2(DIV);
  localparam logic [TW-1:0]  DIV_M1      = TW'(DIV - 1);
  localparam logic [15:0]    DATA_ADDR   = BASE_ADDR + UART_DATA;
  localparam logic [15:0]    STATUS_ADDR = BASE_ADDR + UART_STATUS;

  tx_state_t     state;
  logic [TW-1:0] timer;
  logic [7:0]    shreg;
  logic [2:0]    bit_idx;
  logic          overflow;
  logic          line_bit;
  logic [7:0]    status_word;
`ifdef UART_TX_PARITY_EN
  logic          parity_bit;
`endif

  logic          write_data;
  logic          read_status;
  logic          fifo_pop;
  logic [7:0]    fifo_head;
  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_dropped;

  assign write_data  = write_en & (address == DATA_ADDR);
  assign read_status = ~write_en & (address == STATUS_ADDR);
  assign fifo_pop    = (state == ST_IDLE) & ~fifo_empty;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (write_data),
    .push_data (data_in),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .dropped   (fifo_dropped),
    .count     (fifo_count_dbg)
  );

  always_comb begin
    status_word                = 8'h00;
    status_word[STAT_BUSY]     = (state != ST_IDLE);
    status_word[STAT_FULL]     = fifo_full;
    status_word[STAT_EMPTY]    = fifo_empty;
    status_word[STAT_OVERFLOW] = overflow;
  end

  // Sticky overflow. Set and clear never coincide: setting needs a write,
  // clearing needs a read.
  always_ff @(posedge clock) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (fifo_dropped) begin
      overflow <= 1'b1;
    end else if (read_status) begin
      overflow <= 1'b0;
    end
  end

  // Read data is registered so it lines up with RAM read timing.
  always_ff @(posedge clock) begin
    if (reset) begin
      data_out <= 8'h00;
    end else if (read_status) begin
      data_out <= status_word;
    end else begin
      data_out <= 8'h00;
    end
  end

  // Line level implied by the current state; tx registers it, so tx lags
  // the state by one clock (the first start-bit clock follows the pop edge).
  always_comb begin
    line_bit = 1'b1;
    case (state)
      ST_START:  line_bit = 1'b0;
      ST_DATA:   line_bit = shreg[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: line_bit = parity_bit;
`endif
      default:   line_bit = 1'b1;
    endcase
  end

  // Transmit FSM. Every non-idle state lasts DIV clocks: timer loads DIV-1
  // on entry and the state advances on the clock where it reads zero.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_IDLE;
      timer      <= '0;
      shreg      <= 8'h00;
      bit_idx    <= 3'd0;
      tx         <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      tx <= line_bit;
      case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            shreg      <= fifo_head;
`ifdef UART_TX_PARITY_EN
            parity_bit <= ^fifo_head;
`endif
            timer      <= DIV_M1;
            state      <= ST_START;
          end
        end
        ST_START: begin
          if (timer == '0) begin
            timer   <= DIV_M1;
            bit_idx <= 3'd0;
            state   <= ST_DATA;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        ST_DATA: begin
          if (timer == '0) begin
            timer   <= DIV_M1;
            shreg   <= {1'b0, shreg[7:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state <= ST_PARITY;
`else
              state <= ST_STOP;
`endif
            end
          end else begin
            timer <= timer - 1'b1;
          end
        end
`ifdef UART_TX_PARITY_EN
        ST_PARITY: begin
          if (timer == '0) begin
            timer <= DIV_M1;
            state <= ST_STOP;
          end else begin
            timer <= timer - 1'b1;
          end
        end
`endif
        ST_STOP: begin
          if (timer == '0) begin
            state <= ST_IDLE;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign irq_empty = fifo_empty & (state == ST_IDLE);
  assign state_dbg = state;

endmodule

// File: tb/tb_uart_tx_port.sv
// Bench for uart_tx_port with CLK_HZ=8, BAUD=1 (8 clocks per bit) and the
// register window at F200. Each scenario task drives the bus and compares
// outputs against hand-derived values; a line monitor decodes tx into rx_q.
// Macro UART_TX_PARITY_EN selects the 8E1 checks.
module tb_uart_tx_port;

  localparam int DIV = 8;
`ifdef UART_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] address = 16'h0000;
  logic        write_en = 1'b0;
  logic [7:0]  data_in = 8'h00;
  logic [7:0]  data_out;
  logic        tx;
  logic        irq_empty;
  logic [2:0]  state_dbg;
  logic [4:0]  fifo_count_dbg;

  int checks = 0;
  int fails  = 0;
  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];
  int rx_stop_errs = 0;
  logic [7:0] mon_byte;

  uart_tx_port #(
    .BASE_ADDR  (16'hF200),
    .CLK_HZ     (8),
    .BAUD       (1),
    .FIFO_DEPTH (16)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .address        (address),
    .write_en       (write_en),
    .data_in        (data_in),
    .data_out       (data_out),
    .tx             (tx),
    .irq_empty      (irq_empty),
    .state_dbg      (state_dbg),
    .fifo_count_dbg (fifo_count_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- line monitor ----------------
  // Detects a start bit on the falling edge of the clock, then samples each
  // bit near its centre.
  initial begin
    forever begin
      @(negedge clock);
      if (tx === 1'b0 && reset === 1'b0) begin
        repeat (DIV + DIV / 2) @(negedge clock);
        for (int i = 0; i < 8; i++) begin
          mon_byte[i] = tx;
          if (i < 7) repeat (DIV) @(negedge clock);
        end
`ifdef UART_TX_PARITY_EN
        repeat (DIV) @(negedge clock);
`endif
        repeat (DIV) @(negedge clock);
        if (tx !== 1'b1) rx_stop_errs++;
        rx_q.push_back(mon_byte);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_bus();
    address  = 16'h0000;
    write_en = 1'b0;
    data_in  = 8'h00;
  endtask

  // Present a write for exactly one rising edge; returns 1ns after it.
  task automatic write_byte(input logic [15:0] a, input logic [7:0] d);
    address  = a;
    data_in  = d;
    write_en = 1'b1;
    tick();
    write_en = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1;
    idle_bus();
    repeat (3) tick();
    checks++; if (tx !== 1'b1) begin fails++; $display("FAIL reset_tx: got %b expected 1", tx); end
    checks++; if (data_out !== 8'h00) begin fails++; $display("FAIL reset_data_out: got %h expected 00", data_out); end
    checks++; if (irq_empty !== 1'b1) begin fails++; $display("FAIL reset_irq: got %b expected 1", irq_empty); end
    checks++; if (state_dbg !== 3'd0) begin fails++; $display("FAIL reset_state: got %0d expected 0", state_dbg); end
    checks++; if (fifo_count_dbg !== 5'd0) begin fails++; $display("FAIL reset_count: got %0d expected 0", fifo_count_dbg); end
    reset   = 1'b0;
    address = 16'hF201;
    tick();
    checks++; if (data_out !== 8'h04) begin fails++; $display("FAIL reset_status: got %h expected 04", data_out); end
    checks++; if (tx !== 1'b1) begin fails++; $display("FAIL reset_tx_after: got %b expected 1", tx); end
    checks++; if (irq_empty !== 1'b1) begin fails++; $display("FAIL reset_irq_after: got %b expected 1", irq_empty); end
    idle_bus();
    tick();
    checks++; if (data_out !== 8'h00) begin fails++; $display("FAIL deselect_data_out: got %h expected 00", data_out); end
  endtask

  // One frame of byte b into an idle block, checked clock by clock.
  // After write edge N: tx=0 at N+2..N+9, data bit i at N+10+8i..N+17+8i,
  // optional parity at N+74..N+81, stop until N+1+8*FB. STATUS is read every
  // cycle: 00 at N+1 (byte queued, not yet started), 05 while busy, 04 after.
  task automatic test_single_frame(input logic [7:0] b, input logic par);
    logic       exp_tx;
    logic [7:0] exp_do;
    logic       exp_irq;
    rx_q.delete();
    exp_q.delete();
    exp_q.push_back(b);
    write_byte(16'hF200, b);
    checks++; if (fifo_count_dbg !== 5'd1) begin fails++; $display("FAIL frame_count_after_push: got %0d expected 1", fifo_count_dbg); end
    checks++; if (irq_empty !== 1'b0) begin fails++; $display("FAIL frame_irq_after_push: got %b expected 0", irq_empty); end
    address = 16'hF201;
    for (int k = 1; k <= 2 + 8 * FB; k++) begin
      tick();
      if (k < 2)                       exp_tx = 1'b1;
      else if (k < 10)                 exp_tx = 1'b0;
      else if (k < 74)                 exp_tx = b[(k - 10) / 8];
      else if (FB == 11 && k < 82)     exp_tx = par;
      else                             exp_tx = 1'b1;
      if (k == 1)                      exp_do = 8'h00;
      else if (k <= 1 + 8 * FB)        exp_do = 8'h05;
      else                             exp_do = 8'h04;
      exp_irq = (k >= 1 + 8 * FB);
      checks++; if (tx !== exp_tx) begin fails++; $display("FAIL frame_tx byte=%h k=%0d: got %b expected %b", b, k, tx, exp_tx); end
      checks++; if (data_out !== exp_do) begin fails++; $display("FAIL frame_status byte=%h k=%0d: got %h expected %h", b, k, data_out, exp_do); end
      checks++; if (irq_empty !== exp_irq) begin fails++; $display("FAIL frame_irq byte=%h k=%0d: got %b expected %b", b, k, irq_empty, exp_irq); end
    end
    idle_bus();
    checks++; if (rx_q.size() !== 1) begin fails++; $display("FAIL frame_rx_count: got %0d expected 1", rx_q.size()); end
    if (rx_q.size() > 0) begin
      checks++; if (rx_q[0] !== exp_q[0]) begin fails++; $display("FAIL frame_rx_byte: got %h expected %h", rx_q[0], exp_q[0]); end
    end
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    test_single_frame(8'h07, 1'b1);
    test_single_frame(8'h03, 1'b0);
  endtask
`endif

  task automatic test_outside_window();
    int low_cycles;
    rx_q.delete();
    write_byte(16'hF1FF, 8'hAA);
    checks++; if (fifo_count_dbg !== 5'd0) begin fails++; $display("FAIL win_count_f1ff: got %0d expected 0", fifo_count_dbg); end
    checks++; if (data_out !== 8'h00) begin fails++; $display("FAIL win_data_out_f1ff: got %h expected 00", data_out); end
    write_byte(16'hF202, 8'hAA);
    checks++; if (fifo_count_dbg !== 5'd0) begin fails++; $display("FAIL win_count_f202: got %0d expected 0", fifo_count_dbg); end
    checks++; if (data_out !== 8'h00) begin fails++; $display("FAIL win_data_out_f202: got %h expected 00", data_out); end
    write_byte(16'hF201, 8'hAA);
    checks++; if (fifo_count_dbg !== 5'd0) begin fails++; $display("FAIL win_count_status_write: got %0d expected 0", fifo_count_dbg); end
    checks++; if (data_out !== 8'h00) begin fails++; $display("FAIL win_data_out_status_write: got %h expected 00", data_out); end
    address = 16'hF1FF; tick();
    checks++; if (data_out !== 8'h00) begin fails++; $display("FAIL win_read_f1ff: got %h expected 00", data_out); end
    address = 16'hF202; tick();
    checks++; if (data_out !== 8'h00) begin fails++; $display("FAIL win_read_f202: got %h expected 00", data_out); end
    address = 16'hF200; tick();
    checks++; if (data_out !== 8'h00) begin fails++; $display("FAIL win_read_data_reg: got %h expected 00", data_out); end
    address = 16'hF201; tick();
    checks++; if (data_out !== 8'h04) begin fails++; $display("FAIL win_read_status: got %h expected 04", data_out); end
    idle_bus();
    low_cycles = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (tx !== 1'b1) low_cycles++;
    end
    checks++; if (low_cycles !== 0) begin fails++; $display("FAIL win_tx_idle: got %0d low cycles expected 0", low_cycles); end
    checks++; if (irq_empty !== 1'b1) begin fails++; $display("FAIL win_irq: got %b expected 1", irq_empty); end
    checks++; if (rx_q.size() !== 0) begin fails++; $display("FAIL win_rx_count: got %0d expected 0", rx_q.size()); end
  endtask

  // 20 writes on consecutive edges: 00 is popped by the second edge, 01..10
  // fill the 16 entries, 11..13 are dropped and set overflow.
  task automatic test_back_to_back();
    int budget;
    logic [7:0] got;
    logic [7:0] want;
    rx_q.delete();
    exp_q.delete();
    rx_stop_errs = 0;
    for (int i = 0; i < 20; i++) begin
      write_byte(16'hF200, 8'(i));
      if (i < 17) exp_q.push_back(8'(i));
    end
    checks++; if (fifo_count_dbg !== 5'd16) begin fails++; $display("FAIL b2b_count_full: got %0d expected 16", fifo_count_dbg); end
    address = 16'hF201;
    tick();
    checks++; if (data_out !== 8'h0B) begin fails++; $display("FAIL b2b_status_first: got %h expected 0b", data_out); end
    tick();
    checks++; if (data_out !== 8'h03) begin fails++; $display("FAIL b2b_status_second: got %h expected 03", data_out); end
    idle_bus();
    budget = 0;
    while (rx_q.size() < 17 && budget < 17 * (8 * FB + 1) + 400) begin
      tick();
      budget++;
    end
    checks++; if (rx_q.size() !== 17) begin fails++; $display("FAIL b2b_rx_count: got %0d expected 17", rx_q.size()); end
    while (exp_q.size() > 0 && rx_q.size() > 0) begin
      want = exp_q.pop_front();
      got  = rx_q.pop_front();
      checks++; if (got !== want) begin fails++; $display("FAIL b2b_rx_byte: got %h expected %h", got, want); end
    end
    budget = 0;
    while (irq_empty !== 1'b1 && budget < 200) begin
      tick();
      budget++;
    end
    checks++; if (irq_empty !== 1'b1) begin fails++; $display("FAIL b2b_irq_final: got %b expected 1", irq_empty); end
    repeat (100) tick();
    checks++; if (rx_q.size() !== 0) begin fails++; $display("FAIL b2b_extra_frames: got %0d expected 0", rx_q.size()); end
    checks++; if (rx_stop_errs !== 0) begin fails++; $display("FAIL b2b_stop_bits: got %0d bad stop bits expected 0", rx_stop_errs); end
    address = 16'hF201;
    tick();
    checks++; if (data_out !== 8'h04) begin fails++; $display("FAIL b2b_status_final: got %h expected 04", data_out); end
    idle_bus();
    tick();
  endtask

  // Byte 00 starts at edge N+1; byte 11 waits in the FIFO. Reset is sampled
  // at N+37, inside data bit 3 (tx low at N+34..N+41).
  task automatic test_reset_midframe();
    int low_cycles;
    rx_q.delete();
    write_byte(16'hF200, 8'h00);
    write_byte(16'hF200, 8'h11);
    idle_bus();
    repeat (35) tick();
    checks++; if (tx !== 1'b0) begin fails++; $display("FAIL mid_tx_bit3: got %b expected 0", tx); end
    checks++; if (state_dbg !== 3'd2) begin fails++; $display("FAIL mid_state_data: got %0d expected 2", state_dbg); end
    checks++; if (fifo_count_dbg !== 5'd1) begin fails++; $display("FAIL mid_count_queued: got %0d expected 1", fifo_count_dbg); end
    reset = 1'b1;
    tick();
    checks++; if (tx !== 1'b1) begin fails++; $display("FAIL mid_tx_after_reset: got %b expected 1", tx); end
    checks++; if (state_dbg !== 3'd0) begin fails++; $display("FAIL mid_state_after_reset: got %0d expected 0", state_dbg); end
    checks++; if (fifo_count_dbg !== 5'd0) begin fails++; $display("FAIL mid_count_flushed: got %0d expected 0", fifo_count_dbg); end
    reset   = 1'b0;
    address = 16'hF201;
    tick();
    checks++; if (data_out !== 8'h04) begin fails++; $display("FAIL mid_status: got %h expected 04", data_out); end
    idle_bus();
    low_cycles = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (tx !== 1'b1) low_cycles++;
    end
    checks++; if (low_cycles !== 0) begin fails++; $display("FAIL mid_no_more_frames: got %0d low cycles expected 0", low_cycles); end
    checks++; if (irq_empty !== 1'b1) begin fails++; $display("FAIL mid_irq: got %b expected 1", irq_empty); end
    rx_q.delete();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single_frame(8'h55, 1'b0);
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    test_outside_window();
    test_back_to_back();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
